cmd_cpl_poster: RTL and testbench

CMD_CPL_POSTER -- requirements
Module: cmd_cpl_poster

---
 rtl/cmd_cpl_poster_pkg.sv | 42 ++++
 rtl/cpl_sync_fifo.sv | 60 ++++++
 rtl/cmd_cpl_poster.sv | 190 +++++++++++++++++++
 tb/tb_cmd_cpl_poster.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_cpl_poster_pkg.sv
// Shared types, field widths and status codes for the completion poster.
package cmd_cpl_poster_pkg;

   // Completion ring entry layout: {phase, pad, status, proc_id, seq}
   localparam int unsigned CPL_STATUS_W  = 8;
   localparam int unsigned CPL_PROC_ID_W = 8;
   localparam int unsigned CPL_SEQ_W     = 8;
   localparam int unsigned CPL_PAD_W     = 7;
   localparam int unsigned CPL_ENTRY_W   = 1 + CPL_PAD_W + CPL_STATUS_W + CPL_PROC_ID_W + CPL_SEQ_W;
   localparam int unsigned CPL_PEND_W    = 8;

   // Completion status codes reported by the command processor
   localparam logic [CPL_STATUS_W-1:0] CPL_ST_SUCCESS      = 8'h00;
   localparam logic [CPL_STATUS_W-1:0] CPL_ST_INVALID_OP   = 8'h01;
   localparam logic [CPL_STATUS_W-1:0] CPL_ST_ABORTED      = 8'h02;
   localparam logic [CPL_STATUS_W-1:0] CPL_ST_INTERNAL_ERR = 8'h06;

   // Poster sequencing states
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      WAIT_ACK = 2'd2
   } cpl_state_e;

   // Staged completion request
   typedef struct packed {
      logic [CPL_STATUS_W-1:0]  status;
      logic [CPL_PROC_ID_W-1:0] proc_id;
   } cpl_req_t;

   localparam int unsigned CPL_REQ_W = $bits(cpl_req_t);

   // Assemble a ring entry from its fields
   function automatic logic [CPL_ENTRY_W-1:0] cpl_pack_entry(
      input logic                 phase,
      input cpl_req_t             req,
      input logic [CPL_SEQ_W-1:0] seq
   );
      return {phase, {CPL_PAD_W{1'b0}}, req.status, req.proc_id, seq};
   endfunction

endpackage

// File: rtl/cpl_sync_fifo.sv
// Synchronous show-ahead FIFO with full/empty flags; DEPTH must be a power of 2 (>= 2).
module cpl_sync_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && (r_count != FULL_CNT);
   assign w_pop   = i_pop && (r_count != '0);
   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_rdata = r_mem[r_rd_ptr];

   // Storage write; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointer and occupancy tracking; simultaneous push and pop keeps the count
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/cmd_cpl_poster.sv
// Stages completion requests, posts them into a host completion ring and
// raises a coalesced interrupt on entry count or idle timeout.
module cmd_cpl_poster
   import cmd_cpl_poster_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned RING_ENTRIES = 16,
   parameter int unsigned COAL_CNT     = 4,
   parameter int unsigned COAL_TIMEOUT = 64
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            crq_start,
   output logic                            crq_ready,
   input  logic [CPL_STATUS_W-1:0]         crq_status,
   input  logic [CPL_PROC_ID_W-1:0]        crq_proc_id,
   output logic                            mem_wr_req,
   input  logic                            mem_wr_ack,
   output logic [$clog2(RING_ENTRIES)-1:0] mem_wr_idx,
   output logic [CPL_ENTRY_W-1:0]          mem_wr_data,
   input  logic [$clog2(RING_ENTRIES)-1:0] host_head,
   output logic                            ring_full,
   output logic                            irq,
   input  logic                            irq_ack
);

   localparam int unsigned IDX_W = $clog2(RING_ENTRIES);
   localparam int unsigned TMR_W = $clog2(COAL_TIMEOUT + 1);
   localparam logic [IDX_W-1:0]      TAIL_LAST  = IDX_W'(RING_ENTRIES - 1);
   localparam logic [TMR_W-1:0]      TMR_LIMIT  = TMR_W'(COAL_TIMEOUT);
   localparam logic [CPL_PEND_W-1:0] COAL_CNT_L = CPL_PEND_W'(COAL_CNT);
   localparam logic [CPL_PEND_W-1:0] PEND_MAX   = '1;

   cpl_state_e             r_state;
   cpl_state_e             w_state_nxt;
   logic [IDX_W-1:0]       r_tail;
   logic [CPL_SEQ_W-1:0]   r_seq;
   logic                   r_phase;
   logic [CPL_PEND_W-1:0]  r_pending;
   logic [CPL_PEND_W-1:0]  w_pending_nxt;
   logic [TMR_W-1:0]       r_timer;
   logic [TMR_W-1:0]       w_timer_nxt;
   logic                   r_irq;
   logic                   w_irq_nxt;
   logic                   r_mem_wr_req;
   logic                   w_req_nxt;
   logic [IDX_W-1:0]       r_mem_wr_idx;
   logic [IDX_W-1:0]       w_idx_nxt;
   logic [CPL_ENTRY_W-1:0] r_mem_wr_data;
   logic [CPL_ENTRY_W-1:0] w_data_nxt;

   logic                   w_fifo_full;
   logic                   w_fifo_empty;
   logic                   w_push;
   logic                   w_post;
   logic                   w_ring_full;
   cpl_req_t               w_fifo_wdata;
   cpl_req_t               w_fifo_rdata;

   assign w_push       = crq_start && !w_fifo_full;
   assign w_post       = (r_state == WAIT_ACK) && mem_wr_ack;
   assign w_ring_full  = ((r_tail + IDX_W'(1)) == host_head);
   assign w_fifo_wdata = '{status: crq_status, proc_id: crq_proc_id};

   assign crq_ready   = !w_fifo_full;
   assign ring_full   = w_ring_full;
   assign mem_wr_req  = r_mem_wr_req;
   assign mem_wr_idx  = r_mem_wr_idx;
   assign mem_wr_data = r_mem_wr_data;
   assign irq         = r_irq;

   cpl_sync_fifo #(
      .WIDTH (CPL_REQ_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata (w_fifo_wdata),
      .i_pop   (w_post),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and next write-request outputs; entry is captured on leaving IDLE
   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = r_mem_wr_req;
      w_idx_nxt   = r_mem_wr_idx;
      w_data_nxt  = r_mem_wr_data;
      case (r_state)
         IDLE: begin
            if (!w_fifo_empty && !w_ring_full) begin
               w_state_nxt = WRITE;
               w_req_nxt   = 1'b1;
               w_idx_nxt   = r_tail;
               w_data_nxt  = cpl_pack_entry(r_phase, w_fifo_rdata, r_seq);
            end
         end
         WRITE: begin
            w_state_nxt = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (mem_wr_ack) begin
               w_state_nxt = IDLE;
               w_req_nxt   = 1'b0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_req_nxt   = 1'b0;
         end
      endcase
   end

   // Registered ring-write request outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem_wr_req  <= 1'b0;
         r_mem_wr_idx  <= '0;
         r_mem_wr_data <= '0;
      end else begin
         r_mem_wr_req  <= w_req_nxt;
         r_mem_wr_idx  <= w_idx_nxt;
         r_mem_wr_data <= w_data_nxt;
      end
   end

   // Ring producer position: tail, sequence number and wrap phase advance per post
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tail  <= '0;
         r_seq   <= '0;
         r_phase <= 1'b1;
      end else if (w_post) begin
         r_tail <= r_tail + IDX_W'(1);
         r_seq  <= r_seq + CPL_SEQ_W'(1);
         if (r_tail == TAIL_LAST) begin
            r_phase <= ~r_phase;
         end
      end
   end

   // Interrupt coalescing: count posts and idle cycles; irq_ack wins over the count
   always_comb begin
      w_pending_nxt = r_pending;
      w_timer_nxt   = r_timer;
      w_irq_nxt     = r_irq;
      if (w_post && (r_pending != PEND_MAX)) begin
         w_pending_nxt = r_pending + CPL_PEND_W'(1);
      end
      if (irq_ack) begin
         w_pending_nxt = w_post ? CPL_PEND_W'(1) : '0;
      end
      if (irq_ack || w_post) begin
         w_timer_nxt = '0;
      end else if ((r_pending != '0) && !r_irq && (r_timer != TMR_LIMIT)) begin
         w_timer_nxt = r_timer + TMR_W'(1);
      end
      if (irq_ack) begin
         w_irq_nxt = 1'b0;
      end else if ((w_pending_nxt >= COAL_CNT_L) || (w_timer_nxt >= TMR_LIMIT)) begin
         w_irq_nxt = 1'b1;
      end
   end

   // Coalescing state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pending <= '0;
         r_timer   <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         r_timer   <= w_timer_nxt;
         r_irq     <= w_irq_nxt;
      end
   end

endmodule

// File: tb/tb_cmd_cpl_poster.sv
// Directed and randomized bench for cmd_cpl_poster with a queue-based reference model.
module tb_cmd_cpl_poster;

   localparam int unsigned FIFO_DEPTH   = 4;
   localparam int unsigned RING_ENTRIES = 16;
   localparam int unsigned COAL_CNT     = 4;
   localparam int unsigned COAL_TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        crq_start = 1'b0;
   logic        crq_ready;
   logic [7:0]  crq_status = '0;
   logic [7:0]  crq_proc_id = '0;
   logic        mem_wr_req;
   logic        mem_wr_ack = 1'b0;
   logic [3:0]  mem_wr_idx;
   logic [31:0] mem_wr_data;
   logic [3:0]  host_head = '0;
   logic        ring_full;
   logic        irq;
   logic        irq_ack = 1'b0;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: entries accepted but not yet posted, plus posting and coalescing counters
   logic [15:0] m_q[$];
   int          m_posts   = 0;
   int          m_pending = 0;
   int          m_idle    = 0;
   bit          m_irq     = 1'b0;
   bit          exp_post  = 1'b0;
   bit          host_follow = 1'b0;
   logic [31:0] last_data = '0;

   cmd_cpl_poster #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .RING_ENTRIES (RING_ENTRIES),
      .COAL_CNT     (COAL_CNT),
      .COAL_TIMEOUT (COAL_TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .crq_start   (crq_start),
      .crq_ready   (crq_ready),
      .crq_status  (crq_status),
      .crq_proc_id (crq_proc_id),
      .mem_wr_req  (mem_wr_req),
      .mem_wr_ack  (mem_wr_ack),
      .mem_wr_idx  (mem_wr_idx),
      .mem_wr_data (mem_wr_data),
      .host_head   (host_head),
      .ring_full   (ring_full),
      .irq         (irq),
      .irq_ack     (irq_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One clock: apply the model's view of this edge, then check the always-observable outputs
   task automatic tick();
      bit          do_rst;
      bit          push_ok;
      bit          post_ok;
      bit          ack_i;
      logic [15:0] e_in;
      int          idle_n;
      int          pend_n;
      do_rst  = reset;
      push_ok = crq_start && (m_q.size() < FIFO_DEPTH);
      post_ok = exp_post && mem_wr_ack;
      ack_i   = irq_ack;
      e_in    = {crq_status, crq_proc_id};
      @(posedge clk);
      if (do_rst) begin
         m_q.delete();
         m_posts = 0; m_pending = 0; m_idle = 0; m_irq = 1'b0;
      end else begin
         if (post_ok && m_q.size() > 0) void'(m_q.pop_front());
         if (push_ok) m_q.push_back(e_in);
         if (ack_i || post_ok)                 idle_n = 0;
         else if (m_pending > 0 && !m_irq)     idle_n = m_idle + 1;
         else                                  idle_n = m_idle;
         if (ack_i)        pend_n = post_ok ? 1 : 0;
         else if (post_ok) pend_n = (m_pending < 255) ? m_pending + 1 : 255;
         else              pend_n = m_pending;
         if (ack_i) m_irq = 1'b0;
         else       m_irq = m_irq || (pend_n >= COAL_CNT) || (idle_n >= COAL_TIMEOUT);
         m_pending = pend_n;
         m_idle    = idle_n;
         if (post_ok) m_posts++;
         if (host_follow) host_head = 4'(m_posts % RING_ENTRIES);
      end
      #1;
      chk("crq_ready", crq_ready, m_q.size() < FIFO_DEPTH);
      chk("irq", irq, m_irq);
      chk("ring_full", ring_full, ((m_posts + 1) % RING_ENTRIES) == host_head);
   endtask

   task automatic do_reset();
      host_head = '0;
      crq_start = 1'b0; mem_wr_ack = 1'b0; irq_ack = 1'b0; exp_post = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic push(input logic [7:0] st, input logic [7:0] id);
      crq_start = 1'b1; crq_status = st; crq_proc_id = id;
      tick();
      crq_start = 1'b0;
   endtask

   // Wait for the ring write, check it against the model, hold, then acknowledge
   task automatic do_write(input int extra, input bit with_irq_ack);
      bit          seen;
      int          n;
      logic [15:0] e;
      logic [31:0] exp_d;
      seen = mem_wr_req;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         seen = mem_wr_req;
      end
      chk("req_seen", 32'(seen), 32'd1);
      if (!seen || m_q.size() == 0) return;
      e     = m_q[0];
      n     = m_posts;
      exp_d = {((n / RING_ENTRIES) % 2 == 0) ? 1'b1 : 1'b0, 7'b0, e, 8'(n)};
      last_data = mem_wr_data;
      chk("wr_idx", 32'(mem_wr_idx), n % RING_ENTRIES);
      chk("wr_data", mem_wr_data, exp_d);
      for (int k = 0; k <= extra; k++) begin
         tick();
         chk("req_hold", 32'(mem_wr_req), 32'd1);
         chk("data_hold", mem_wr_data, exp_d);
         chk("idx_hold", 32'(mem_wr_idx), n % RING_ENTRIES);
      end
      mem_wr_ack = 1'b1; irq_ack = with_irq_ack; exp_post = 1'b1;
      tick();
      mem_wr_ack = 1'b0; irq_ack = 1'b0; exp_post = 1'b0;
      chk("req_drop", 32'(mem_wr_req), 32'd0);
   endtask

   task automatic expect_idle(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         tick();
         chk("no_req", 32'(mem_wr_req), 32'd0);
      end
   endtask

   task automatic pulse_irq_ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   initial begin
      int first;

      // Reset values
      do_reset();
      chk("rst_ready", 32'(crq_ready), 32'd1);
      chk("rst_req", 32'(mem_wr_req), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_idx", 32'(mem_wr_idx), 32'd0);
      chk("rst_data", mem_wr_data, 32'd0);

      // Single post, then confirm tail and seq advanced
      push(8'h00, 8'h05);
      do_write(0, 1'b0);
      chk("single_data", last_data, 32'h8000_0500);
      host_head = 4'd2;
      #1;
      chk("single_tail1", 32'(ring_full), 32'd1);
      host_head = 4'd0;
      push(8'h01, 8'h07);
      do_write(1, 1'b0);
      chk("second_data", last_data, 32'h8001_0701);

      // Backpressure: five back-to-back starts, no acks
      do_reset();
      for (int i = 0; i < 5; i++) begin
         push(8'h10 + 8'(i), 8'h20 + 8'(i));
         if (i == 3) chk("bp_ready_low", 32'(crq_ready), 32'd0);
      end
      for (int i = 0; i < 4; i++) do_write(i % 3, 1'b0);
      expect_idle(10);

      // Ring full and wrap
      do_reset();
      for (int i = 0; i < 15; i++) begin
         push(8'(CPL_ST(i)), 8'(i));
         do_write(0, 1'b0);
      end
      chk("ring_full_15", 32'(ring_full), 32'd1);
      push(8'h06, 8'h0F);
      expect_idle(8);
      host_head = 4'd1;
      do_write(0, 1'b0);
      chk("idx15_data", last_data, 32'h8006_0F0F);
      chk("wrap_full", 32'(ring_full), 32'd1);
      host_head = 4'd5;
      push(8'h02, 8'h44);
      do_write(0, 1'b0);
      chk("phase_flip", 32'(last_data[31]), 32'd0);

      // Count coalescing
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push(8'h00, 8'(8'h30 + 8'(i)));
         do_write(i % 2, 1'b0);
         if (i == 2) chk("coal_irq_3", 32'(irq), 32'd0);
      end
      chk("coal_irq_4", 32'(irq), 32'd1);
      pulse_irq_ack();
      chk("coal_ack", 32'(irq), 32'd0);
      for (int k = 0; k < 70; k++) tick();
      chk("coal_pending0", 32'(irq), 32'd0);

      // Timeout coalescing, then simultaneous irq_ack and mem_wr_ack
      do_reset();
      push(8'h01, 8'h09);
      do_write(0, 1'b0);
      first = -1;
      for (int k = 1; k <= 70; k++) begin
         tick();
         if (irq && first < 0) first = k;
      end
      chk("timeout_lat", 32'(first), 32'd64);
      push(8'h00, 8'h0A);
      do_write(0, 1'b1);
      chk("sim_ack_irq", 32'(irq), 32'd0);
      for (int i = 0; i < 3; i++) begin
         push(8'h00, 8'(8'h50 + 8'(i)));
         do_write(0, 1'b0);
         chk("sim_ack_count", 32'(irq), (i == 2) ? 32'd1 : 32'd0);
      end

      // Reset mid-handshake abandons the entry
      do_reset();
      push(8'h02, 8'h33);
      for (int k = 0; k < 10 && !mem_wr_req; k++) tick();
      chk("rst_mid_req", 32'(mem_wr_req), 32'd1);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_mid_drop", 32'(mem_wr_req), 32'd0);
      mem_wr_ack = 1'b1;
      tick();
      mem_wr_ack = 1'b0;
      host_head = 4'd1;
      #1;
      chk("rst_mid_tail0", 32'(ring_full), 32'd1);
      host_head = 4'd0;
      expect_idle(8);
      chk("rst_mid_ready", 32'(crq_ready), 32'd1);

      // Randomized traffic with a host that consumes immediately
      do_reset();
      host_follow = 1'b1;
      for (int it = 0; it < 80; it++) begin
         if ($urandom % 4 < 2) begin
            int np;
            np = 1 + int'($urandom % 3);
            for (int j = 0; j < np; j++) push(8'($urandom), 8'($urandom));
         end
         if (m_q.size() > 0 && ($urandom % 3) != 0) begin
            do_write(int'($urandom % 3), ($urandom % 4) == 0);
            if ($urandom % 5 == 0) begin
               mem_wr_ack = 1'b1;
               tick();
               mem_wr_ack = 1'b0;
            end
         end
         if ($urandom % 6 == 0) pulse_irq_ack();
      end
      while (m_q.size() > 0 && n_total < 100000) do_write(0, 1'b0);
      host_follow = 1'b0;
      expect_idle(5);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Cycle through a few status codes for the ring-fill entries
   function automatic int CPL_ST(input int i);
      case (i % 4)
         0:       return 8'h00;
         1:       return 8'h01;
         2:       return 8'h02;
         default: return 8'h06;
      endcase
   endfunction

endmodule
